// File: rtl/gray_code_counter_if.sv
// Control and observation bundle for gray_code_counter.
// The counter connects through the slave modport; whoever drives the counter uses master.
interface gray_code_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             wrap;

  modport master (
    output en,
    output up_dn,
    output load,
    output load_val,
    input  bin_out,
    input  gray_out,
    input  wrap
  );

  modport slave (
    input  en,
    input  up_dn,
    input  load,
    input  load_val,
    output bin_out,
    output gray_out,
    output wrap
  );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a separately registered Gray-code output and a wrap pulse.
// Define GRAY_CODE_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module gray_code_counter #(
  parameter int          WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_code_counter_if.slave    bus
);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  localparam logic [WIDTH-1:0] RST_BIN  = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_min;

  always_comb begin
    at_max = (bin_q == {WIDTH{1'b1}});
    at_min = (bin_q == {WIDTH{1'b0}});
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      bin_d = bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        wrap_d = at_max;
`ifdef GRAY_CODE_COUNTER_SAT_EN
        if (!at_max) bin_d = bin_q + WIDTH'(1);
`else
        bin_d = bin_q + WIDTH'(1);
`endif
      end else begin
        wrap_d = at_min;
`ifdef GRAY_CODE_COUNTER_SAT_EN
        if (!at_min) bin_d = bin_q - WIDTH'(1);
`else
        bin_d = bin_q - WIDTH'(1);
`endif
      end
    end
    // Encode the next value so gray_out comes straight from its own flop.
    gray_d = bin2gray(bin_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter (WIDTH=4, RST_VAL=0) with a reference model.
// Build with GRAY_CODE_COUNTER_SAT_EN defined to exercise the saturating variant.
module tb_gray_code_counter;
  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_code_counter_if #(.WIDTH(W)) bus ();

  gray_code_counter #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Gray table built by reflect-and-prefix, independent of the XOR formula.
  int gray_tab [0:MAX];

  int m_bin      = 0;
  int m_wrap     = 0;
  int m_delta    = -1;
  bit m_valid    = 1'b0;
  int prev_gray  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: update from the inputs sampled on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_bin = 0; m_wrap = 0; m_delta = -1; m_valid = 1'b1;
    end else if (bus.load) begin
      m_bin = int'(bus.load_val); m_wrap = 0; m_delta = -1;
    end else if (bus.en) begin
      m_delta = 1;
      m_wrap  = 0;
      if (bus.up_dn) begin
        if (m_bin == MAX) begin
          m_wrap = 1;
`ifdef GRAY_CODE_COUNTER_SAT_EN
          m_delta = 0;
`else
          m_bin = 0;
`endif
        end else m_bin = m_bin + 1;
      end else begin
        if (m_bin == 0) begin
          m_wrap = 1;
`ifdef GRAY_CODE_COUNTER_SAT_EN
          m_delta = 0;
`else
          m_bin = MAX;
`endif
        end else m_bin = m_bin - 1;
      end
    end else begin
      m_wrap = 0; m_delta = 0;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("bin_vs_model",  int'(bus.bin_out),  m_bin);
      chk("gray_vs_model", int'(bus.gray_out), gray_tab[m_bin]);
      chk("wrap_vs_model", int'(bus.wrap),     m_wrap);
      if (m_delta >= 0)
        chk("gray_bits_changed", $countones(bus.gray_out ^ W'(prev_gray)), m_delta);
      prev_gray = int'(bus.gray_out);
    end
  end

  task automatic cyc(input bit r, input bit l, input int lv, input bit e, input bit u);
    rst = r; bus.load = l; bus.load_val = W'(lv); bus.en = e; bus.up_dn = u;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input int b, input int g, input int w);
    chk({name, "_bin"},  int'(bus.bin_out),  b);
    chk({name, "_gray"}, int'(bus.gray_out), g);
    chk({name, "_wrap"}, int'(bus.wrap),     w);
  endtask

  // Mixed directed vectors: {load, load_val, en, up_dn}
  typedef struct { bit l; int lv; bit e; bit u; } vec_t;
  vec_t vecs [12] = '{
    '{1'b1, 5, 1'b0, 1'b0}, '{1'b0, 0, 1'b1, 1'b1}, '{1'b0, 0, 1'b1, 1'b0},
    '{1'b0, 0, 1'b1, 1'b0}, '{1'b0, 0, 1'b0, 1'b1}, '{1'b0, 0, 1'b1, 1'b0},
    '{1'b0, 0, 1'b1, 1'b0}, '{1'b0, 0, 1'b1, 1'b0}, '{1'b0, 0, 1'b1, 1'b0},
    '{1'b0, 0, 1'b1, 1'b0}, '{1'b0, 0, 1'b1, 1'b1}, '{1'b1, 9, 1'b1, 1'b1}
  };

  initial begin
    gray_tab[0] = 0;
    gray_tab[1] = 1;
    for (int k = 1; k < W; k++)
      for (int i = 0; i < (1 << k); i++)
        gray_tab[(1 << k) + i] = gray_tab[(1 << k) - 1 - i] | (1 << k);

    rst = 1'b1; bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b0; bus.up_dn = 1'b1;
    @(negedge clk);

    // Pin the model's Gray table with hand values.
    chk("tab_9",  gray_tab[9],  4'b1101);
    chk("tab_12", gray_tab[12], 4'b1010);
    chk("tab_15", gray_tab[15], 4'b1000);

    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    expect_out("reset", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      expect_out("hold", 0, 0, 0);
    end

    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 1);
    expect_out("up9", 4'b1001, 4'b1101, 0);

    cyc(0, 1, 4'b1100, 1, 1);
    expect_out("load_prio", 4'b1100, 4'b1010, 0);
    cyc(0, 0, 0, 1, 0);
    expect_out("after_load_dn", 4'b1011, 4'b1110, 0);

    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
`ifdef GRAY_CODE_COUNTER_SAT_EN
    expect_out("down_at_zero", 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    expect_out("down_at_zero2", 0, 0, 1);
`else
    expect_out("down_wrap", 4'b1111, 4'b1000, 1);
    cyc(0, 0, 0, 1, 0);
    expect_out("down_after_wrap", 4'b1110, 4'b1001, 0);
`endif

    cyc(0, 1, 4'b1110, 0, 1);
    cyc(0, 0, 0, 1, 1);
    expect_out("up_to_max", 4'b1111, 4'b1000, 0);
    cyc(0, 0, 0, 1, 1);
`ifdef GRAY_CODE_COUNTER_SAT_EN
    expect_out("up_at_max", 4'b1111, 4'b1000, 1);
`else
    expect_out("up_wrap", 0, 0, 1);
`endif

    cyc(0, 1, 4'b0111, 0, 1);
    cyc(1, 1, 4'b1010, 1, 1);
    expect_out("rst_mid", 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    expect_out("resume", 1, 1, 0);

    cyc(0, 1, 4'b1111, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1);
`ifdef GRAY_CODE_COUNTER_SAT_EN
      expect_out("sat_up", 4'b1111, 4'b1000, 1);
`else
      expect_out("mod_up", i, gray_tab[i], (i == 0) ? 1 : 0);
`endif
    end
    cyc(0, 0, 0, 1, 0);
`ifdef GRAY_CODE_COUNTER_SAT_EN
    expect_out("sat_down", 4'b1110, 4'b1001, 0);
`else
    expect_out("mod_down", 4'b0001, 4'b0001, 0);
`endif

    foreach (vecs[i]) cyc(0, vecs[i].l, vecs[i].lv, vecs[i].e, vecs[i].u);
    expect_out("vec_end", 9, 4'b1101, 0);

    cyc(0, 0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
